// File: rtl/ieee754_pkg.sv
// Shared IEEE-754 single-precision field layout, value classes and the
// unpacked record carried from the unpack stage into the align stage.
package ieee754_pkg;

  localparam int SGN_BIT     = 31;
  localparam int EXP_MSB     = 30;
  localparam int EXP_LSB     = 23;
  localparam int MAN_MSB     = 22;
  localparam int MAN_LSB     = 0;
  localparam int BIAS        = 127;
  localparam int EXP_SPECIAL = 255;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Unpacked single: sign, raw exponent, significand with hidden bit,
  // whether the stored mantissa was nonzero, and the value class.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        mant_nz;
    cls_e        cls;
  } s1_rec_t;

  function automatic cls_e classify(input logic [7:0] exp, input logic [22:0] mant);
    if (exp == 8'(EXP_SPECIAL)) return (mant == '0) ? CLS_INF : CLS_NAN;
    if (exp == 8'd0)            return CLS_ZERO;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fixed_align_shifter.sv
// Align stage datapath: places a normal significand into the
// INT_W.FRAC_W fixed-point field and produces the guard bit (weight
// 2^-(FRAC_W+1)) plus the sticky OR of everything below it.
module fixed_align_shifter
  import ieee754_pkg::*;
#(
  parameter int INT_W  = 5,
  parameter int FRAC_W = 5
) (
  input  logic [7:0]              exp,
  input  logic [23:0]             sig,
  output logic [INT_W+FRAC_W-1:0] mag,
  output logic                    guard,
  output logic                    sticky,
  output logic                    ovf,
  output logic                    tiny
);

  localparam int W  = INT_W + FRAC_W;
  // Field, guard bit, then 24 sticky-region bits so that even the
  // smallest in-range exponent keeps every significand bit visible.
  localparam int XW = W + 25;

  localparam logic signed [9:0] OVF_E  = 10'(INT_W);
  localparam logic signed [9:0] TINY_E = 10'(-(FRAC_W + 1));

  logic signed [9:0] e;
  logic [9:0]        pos;
  logic [5:0]        shamt;
  logic [XW-1:0]     wide;

  assign e   = $signed({2'b00, exp}) - $signed(10'(BIAS));
  // Bit position of the significand LSB inside the extended vector.
  assign pos = e + 10'(FRAC_W + 2);

  assign ovf  = (e >= OVF_E);
  assign tiny = (e < TINY_E);

  // Shift amount is only meaningful in range; clamp it otherwise.
  always_comb begin
    shamt = (ovf || tiny) ? 6'd0 : pos[5:0];
    wide  = {{(XW-24){1'b0}}, sig} << shamt;
  end

  assign mag    = wide[XW-1:25];
  assign guard  = wide[24];
  assign sticky = |wide[23:0];

endmodule

// File: rtl/ieee_to_fixed_pipe.sv
// Three-stage valid/ready converter from IEEE-754 single to
// sign-magnitude INT_W.FRAC_W fixed point with saturation and flags.
// S1 unpacks, S2 aligns, S3 rounds/saturates into the output registers.
// Define IEEE_TO_FIXED_ROUND_NEAREST_EN for round-to-nearest-even in S3;
// otherwise the magnitude is truncated toward zero.
module ieee_to_fixed_pipe
  import ieee754_pkg::*;
#(
  parameter int INT_W  = 5,
  parameter int FRAC_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [INT_W-1:0]  out_digit,
  output logic [FRAC_W-1:0] out_float,
  output logic              out_ovf,
  output logic              out_nan,
  output logic              out_inexact
);

  localparam int W = INT_W + FRAC_W;

  // Stage enables: a stage may load when it is empty or draining.
  logic s1_en, s2_en, s3_en;
  logic s1_valid, s2_valid;

  assign s3_en    = !out_valid || out_ready;
  assign s2_en    = !s2_valid || s3_en;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // ---------------- S1: unpack ----------------
  s1_rec_t s1_d, s1_q;

  // Split the word into fields and classify it.
  always_comb begin
    s1_d.sign    = in[SGN_BIT];
    s1_d.exp     = in[EXP_MSB:EXP_LSB];
    s1_d.mant_nz = |in[MAN_MSB:MAN_LSB];
    s1_d.cls     = classify(in[EXP_MSB:EXP_LSB], in[MAN_MSB:MAN_LSB]);
    s1_d.sig     = (in[EXP_MSB:EXP_LSB] == 8'd0) ? 24'd0 : {1'b1, in[MAN_MSB:MAN_LSB]};
  end

  // S1 register: capture the input word on a transfer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: only valid bits and visible outputs are reset; payload registers
  // are qualified by their valid bit and need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- S2: align ----------------
  logic [W-1:0] sh_mag;
  logic         sh_guard, sh_sticky, sh_ovf, sh_tiny;

  fixed_align_shifter #(
    .INT_W (INT_W),
    .FRAC_W(FRAC_W)
  ) u_align (
    .exp   (s1_q.exp),
    .sig   (s1_q.sig),
    .mag   (sh_mag),
    .guard (sh_guard),
    .sticky(sh_sticky),
    .ovf   (sh_ovf),
    .tiny  (sh_tiny)
  );

  logic         s2_d_sign, s2_d_guard, s2_d_sticky, s2_d_ovf, s2_d_nan;
  logic [W-1:0] s2_d_mag;

  // Resolve special classes, overflow and tiny values around the shifter.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    s2_d_sign   = s1_q.sign;
    s2_d_mag    = '0;
    s2_d_guard  = 1'b0;
    s2_d_sticky = 1'b0;
    s2_d_ovf    = 1'b0;
    s2_d_nan    = 1'b0;
    case (s1_q.cls)
      CLS_NAN: begin
        s2_d_sign = 1'b0;
        s2_d_nan  = 1'b1;
      end
      CLS_INF: begin
        s2_d_mag = '1;
        s2_d_ovf = 1'b1;
      end
      CLS_ZERO: s2_d_sticky = s1_q.mant_nz;
      default: begin
        if (sh_ovf) begin
          s2_d_mag = '1;
          s2_d_ovf = 1'b1;
        end else if (sh_tiny) begin
          s2_d_sticky = 1'b1;
        end else begin
          s2_d_mag    = sh_mag;
          s2_d_guard  = sh_guard;
          s2_d_sticky = sh_sticky;
        end
      end
    endcase
  end

  logic         s2_sign, s2_guard, s2_sticky, s2_ovf, s2_nan;
  logic [W-1:0] s2_mag;

  // S2 register: aligned magnitude with guard/sticky and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign   <= s2_d_sign;
        s2_mag    <= s2_d_mag;
        s2_guard  <= s2_d_guard;
        s2_sticky <= s2_d_sticky;
        s2_ovf    <= s2_d_ovf;
        s2_nan    <= s2_d_nan;
      end
    end
  end

  // ---------------- S3: round / saturate ----------------
  logic [W-1:0] s3_mag;
  logic         s3_ovf;

`ifdef IEEE_TO_FIXED_ROUND_NEAREST_EN
  logic         round_up;
  logic [W:0]   sum;

  // Round to nearest, ties to even; a carry out saturates.
  always_comb begin
    round_up = s2_guard & (s2_sticky | s2_mag[0]);
    sum      = {1'b0, s2_mag} + {{W{1'b0}}, round_up};
    if (sum[W]) begin
      s3_mag = '1;
      s3_ovf = 1'b1;
    end else begin
      s3_mag = sum[W-1:0];
      s3_ovf = s2_ovf;
    end
  end
`else
  // Truncate toward zero: discarded bits only feed the inexact flag.
  always_comb begin
    s3_mag = s2_mag;
    s3_ovf = s2_ovf;
  end
`endif

  logic [W-1:0] out_mag;

  // Output register: holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_mag     <= '0;
      out_ovf     <= 1'b0;
      out_nan     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s3_en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sign    <= s2_sign;
        out_mag     <= s3_mag;
        out_ovf     <= s3_ovf;
        out_nan     <= s2_nan;
        out_inexact <= s2_guard | s2_sticky;
      end
    end
  end

  assign out_digit = out_mag[W-1:FRAC_W];
  assign out_float = out_mag[FRAC_W-1:0];

endmodule

// File: tb/tb_ieee_to_fixed_pipe.sv
// Directed bench for ieee_to_fixed_pipe (INT_W=5, FRAC_W=5): reset state,
// single-word conversions with latency, special values, rounding corner
// cases, a stalled 8-word stream and a mid-stream reset flush.
module tb_ieee_to_fixed_pipe;

  localparam int INT_W  = 5;
  localparam int FRAC_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_word;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [INT_W-1:0]  out_digit;
  logic [FRAC_W-1:0] out_float;
  logic              out_ovf;
  logic              out_nan;
  logic              out_inexact;

  logic [13:0] res;
  assign res = {out_sign, out_digit, out_float, out_ovf, out_nan, out_inexact};

  int n_checks = 0;
  int n_fail   = 0;

  ieee_to_fixed_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_digit  (out_digit),
    .out_float  (out_float),
    .out_ovf    (out_ovf),
    .out_nan    (out_nan),
    .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] pack(input logic s, input logic [4:0] d, input logic [4:0] f,
                                       input logic o, input logic n, input logic i);
    return {s, d, f, o, n, i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word, then check the 3-cycle latency and the result.
  task automatic run_one(input string tag, input logic [31:0] w, input logic [13:0] exp);
    in_word   = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_word  = '0;
    step();
    check({tag, " not early"}, 32'(out_valid), 32'd0);
    step();
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(res), 32'(exp));
    step();
    check({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] words[8];
  logic [13:0] exps[8];
  logic [13:0] q[$];
  logic [13:0] held_res;
  logic        stall_prev;
  logic        saw_full;
  int          cyc, sent, recv;

  initial begin
    words[0] = 32'h3F800000; exps[0] = pack(0, 5'd1,  5'd0,  0, 0, 0);
    words[1] = 32'h40000000; exps[1] = pack(0, 5'd2,  5'd0,  0, 0, 0);
    words[2] = 32'h40400000; exps[2] = pack(0, 5'd3,  5'd0,  0, 0, 0);
    words[3] = 32'h3F000000; exps[3] = pack(0, 5'd0,  5'd16, 0, 0, 0);
    words[4] = 32'hC0800000; exps[4] = pack(1, 5'd4,  5'd0,  0, 0, 0);
    words[5] = 32'h40F80000; exps[5] = pack(0, 5'd7,  5'd24, 0, 0, 0);
    words[6] = 32'h3E800000; exps[6] = pack(0, 5'd0,  5'd8,  0, 0, 0);
    words[7] = 32'h41FFC000; exps[7] = pack(0, 5'd31, 5'd31, 0, 0, 0);

    // Reset state
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset outputs", 32'(res), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    // Single-word conversions
    run_one("5.5",       32'h40B00000, pack(0, 5'd5,  5'd16, 0, 0, 0));
    run_one("-1.25",     32'hBFA00000, pack(1, 5'd1,  5'd8,  0, 0, 0));
    run_one("32.0 ovf",  32'h42000000, pack(0, 5'd31, 5'd31, 1, 0, 0));
    run_one("-inf",      32'hFF800000, pack(1, 5'd31, 5'd31, 1, 0, 0));
    run_one("qnan",      32'h7FC00000, pack(0, 5'd0,  5'd0,  0, 1, 0));
    run_one("neg nan",   32'hFFC00000, pack(0, 5'd0,  5'd0,  0, 1, 0));
    run_one("denormal",  32'h00000001, pack(0, 5'd0,  5'd0,  0, 0, 1));
    run_one("-0",        32'h80000000, pack(1, 5'd0,  5'd0,  0, 0, 0));
    run_one("tiny",      32'h3C000000, pack(0, 5'd0,  5'd0,  0, 0, 1));
    run_one("max exact", 32'h41FFC000, pack(0, 5'd31, 5'd31, 0, 0, 0));
    run_one("tie even",  32'h3C800000, pack(0, 5'd0,  5'd0,  0, 0, 1));
`ifdef IEEE_TO_FIXED_ROUND_NEAREST_EN
    run_one("round up",  32'h3CC00000, pack(0, 5'd0,  5'd1,  0, 0, 1));
    run_one("round sat", 32'h41FFE000, pack(0, 5'd31, 5'd31, 1, 0, 1));
`else
    run_one("round up",  32'h3CC00000, pack(0, 5'd0,  5'd0,  0, 0, 1));
    run_one("round sat", 32'h41FFE000, pack(0, 5'd31, 5'd31, 0, 0, 1));
`endif

    // Stream of 8 words with out_ready low in cycles 4..9
    cyc        = 0;
    sent       = 0;
    recv       = 0;
    stall_prev = 1'b0;
    saw_full   = 1'b0;
    held_res   = '0;
    while (recv < 8 && cyc < 60) begin
      cyc++;
      in_valid  = (sent < 8);
      in_word   = (sent < 8) ? words[sent] : 32'd0;
      out_ready = !(cyc >= 4 && cyc <= 9);
      #1;
      if (stall_prev) check("stall hold", 32'(res), 32'(held_res));
      if (in_valid && !in_ready) begin
        saw_full = 1'b1;
        check("held words at in_ready drop", 32'(sent - recv), 32'd3);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious output", 32'(out_valid), 32'd0);
        else check($sformatf("stream word %0d", recv), 32'(res), 32'(q.pop_front()));
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(exps[sent]);
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held_res   = res;
      step();
    end
    in_valid = 1'b0;
    check("stream received", 32'(recv), 32'd8);
    check("stream in_ready dropped", 32'(saw_full), 32'd1);

    // Mid-stream reset flush
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_word  = words[i];
      step();
    end
    in_valid = 1'b0;
    check("pre-flush out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush outputs", 32'(res), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("flush quiet %0d", i), 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
